// File: rtl/prewish_pkg.sv
// Shared constants and types for the prewish blink sequencer: register map,
// ctrl bit layout and FSM state encoding.
package prewish_pkg;

    localparam int SYSCLK_DIV_BITS_DEF = 22;
    localparam int SEQ_ENTRIES         = 4;

    localparam logic [3:0] ADR_MASK0 = 4'd0;
    localparam logic [3:0] ADR_MASK1 = 4'd1;
    localparam logic [3:0] ADR_MASK2 = 4'd2;
    localparam logic [3:0] ADR_MASK3 = 4'd3;
    localparam logic [3:0] ADR_REP0  = 4'd4;
    localparam logic [3:0] ADR_REP1  = 4'd5;
    localparam logic [3:0] ADR_REP2  = 4'd6;
    localparam logic [3:0] ADR_REP3  = 4'd7;
    localparam logic [3:0] ADR_CTRL  = 4'd8;

    localparam int CTRL_RUN      = 0;
    localparam int CTRL_LOOP     = 1;
    localparam int CTRL_LAST_LSB = 2;

    typedef struct packed {
        logic [1:0] last;
        logic       loop;
        logic       run;
    } ctrl_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADVANCE,
        ST_LOAD,
        ST_DWELL,
        ST_END
    } seq_state_t;

endpackage

// File: rtl/prewish_seq_regs.sv
// Host-side register file: pattern masks, repeat counts, ctrl and the ack.
// loop_eff/last_eff show a ctrl write landing this cycle so the FSM decides on it.
module prewish_seq_regs
    import prewish_pkg::*;
#(
    parameter int NUM_ENTRIES = SEQ_ENTRIES
) (
    input  logic                        CLK_I,
    input  logic                        RST_I,
    input  logic                        STB_I,
    input  logic [3:0]                  ADR_I,
    input  logic [7:0]                  DAT_I,
    input  logic                        run_clr,
    output logic                        ACK_O,
    output logic [NUM_ENTRIES-1:0][7:0] mask,
    output logic [NUM_ENTRIES-1:0][7:0] rep,
    output logic                        run,
    output logic                        loop_eff,
    output logic [1:0]                  last_eff,
    output logic                        ctrl_wr
);

    ctrl_t ctrl_q;
    logic  wr_ctrl;

    always_comb begin
        wr_ctrl  = STB_I && (ADR_I == ADR_CTRL);
        loop_eff = wr_ctrl ? DAT_I[CTRL_LOOP] : ctrl_q.loop;
        last_eff = wr_ctrl ? DAT_I[CTRL_LAST_LSB +: 2] : ctrl_q.last;
        run      = ctrl_q.run;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            ACK_O   <= 1'b0;
            ctrl_wr <= 1'b0;
            ctrl_q  <= '0;
            mask    <= '0;
            rep     <= '0;
        end else begin
            ACK_O   <= STB_I;
            ctrl_wr <= wr_ctrl;
            // A host ctrl write in the same cycle overrides the FSM's RUN clear
            if (run_clr) ctrl_q.run <= 1'b0;
            if (STB_I) begin
                case (ADR_I)
                    ADR_MASK0: mask[0] <= DAT_I;
                    ADR_MASK1: mask[1] <= DAT_I;
                    ADR_MASK2: mask[2] <= DAT_I;
                    ADR_MASK3: mask[3] <= DAT_I;
                    ADR_REP0:  rep[0]  <= DAT_I;
                    ADR_REP1:  rep[1]  <= DAT_I;
                    ADR_REP2:  rep[2]  <= DAT_I;
                    ADR_REP3:  rep[3]  <= DAT_I;
                    ADR_CTRL:  ctrl_q  <= ctrl_t'(DAT_I[3:0]);
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: rtl/prewish_blink_sequencer.sv
// Plays up to four blink patterns into the prewish_blinky mask port, each for
// rep[n] full 8-bit pattern cycles, optionally looping.
module prewish_blink_sequencer
    import prewish_pkg::*;
#(
    parameter int SYSCLK_DIV_BITS = SYSCLK_DIV_BITS_DEF,
    parameter int NUM_ENTRIES     = SEQ_ENTRIES
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic [3:0] ADR_I,
    input  logic [7:0] DAT_I,
    output logic       ACK_O,
    output logic       STB_O,
    output logic [7:0] DAT_O,
    output logic       o_busy,
    output logic [1:0] o_index,
    output logic       o_done
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = SYSCLK_DIV_BITS + 11;

    logic [NUM_ENTRIES-1:0][7:0] mask;
    logic [NUM_ENTRIES-1:0][7:0] rep;
    logic                        run, loop_eff, ctrl_wr, run_clr;
    logic [1:0]                  last_eff;

    seq_state_t       state, state_nxt;
    logic [IDX_W-1:0] cur, cur_nxt;
    logic             played, played_nxt;
    logic [CNT_W-1:0] dwell_cnt, dwell_load;
    logic             busy, abort, restart, finish;

    prewish_seq_regs #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_regs (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .STB_I   (STB_I),
        .ADR_I   (ADR_I),
        .DAT_I   (DAT_I),
        .run_clr (run_clr),
        .ACK_O   (ACK_O),
        .mask    (mask),
        .rep     (rep),
        .run     (run),
        .loop_eff(loop_eff),
        .last_eff(last_eff),
        .ctrl_wr (ctrl_wr)
    );

    // rep * 8 bit periods of 2^SYSCLK_DIV_BITS clocks, minus one for the terminal state
    assign dwell_load = {rep[cur], {(SYSCLK_DIV_BITS + 3){1'b0}}} - CNT_W'(1);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state     <= ST_IDLE;
            cur       <= '0;
            played    <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            state  <= state_nxt;
            cur    <= cur_nxt;
            played <= played_nxt;
            if (state == ST_LOAD)
                dwell_cnt <= dwell_load;
            else if (state == ST_DWELL && dwell_cnt != '0)
                dwell_cnt <= dwell_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        restart    = ctrl_wr && run;
        abort      = ctrl_wr && !run && busy;
        // A loop pass that loaded nothing would spin forever; end it instead
        finish     = (state == ST_END) && !(loop_eff && played);
        state_nxt  = state;
        cur_nxt    = cur;
        played_nxt = played;
        if (restart) begin
            state_nxt  = ST_ADVANCE;
            cur_nxt    = '0;
            played_nxt = 1'b0;
        end else if (abort) begin
            state_nxt = ST_IDLE;
            cur_nxt   = '0;
        end else begin
            case (state)
                ST_ADVANCE: begin
                    if (rep[cur] != 8'd0)  state_nxt = ST_LOAD;
                    else if (cur < last_eff) cur_nxt = cur + IDX_W'(1);
                    else                    state_nxt = ST_END;
                end
                ST_LOAD: begin
                    state_nxt  = ST_DWELL;
                    played_nxt = 1'b1;
                end
                ST_DWELL: begin
                    if (dwell_cnt == '0) begin
                        if (cur < last_eff) begin
                            cur_nxt   = cur + IDX_W'(1);
                            state_nxt = ST_ADVANCE;
                        end else begin
                            state_nxt = ST_END;
                        end
                    end
                end
                ST_END: begin
                    cur_nxt    = '0;
                    played_nxt = 1'b0;
                    state_nxt  = finish ? ST_IDLE : ST_ADVANCE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        STB_O   = 1'b0;
        DAT_O   = 8'h00;
        o_done  = 1'b0;
        run_clr = 1'b0;
        o_busy  = busy;
        o_index = cur;
        if (abort) begin
            STB_O = 1'b1;
        end else if (!restart) begin
            if (state == ST_LOAD) begin
                STB_O = 1'b1;
                DAT_O = mask[cur];
            end else if (finish) begin
                STB_O   = 1'b1;
                o_done  = 1'b1;
                run_clr = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prewish_blink_sequencer.sv
// Scoreboard bench for prewish_blink_sequencer with a short blink bit period.
module tb_prewish_blink_sequencer;

    localparam int DIV         = 2;
    localparam int CYC_PER_REP = 8 * (1 << DIV);
    localparam int NO_LIMIT    = 32'h3fff_ffff;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic       STB_I = 1'b0;
    logic [3:0] ADR_I = '0;
    logic [7:0] DAT_I = '0;
    logic       ACK_O, STB_O, o_busy, o_done;
    logic [7:0] DAT_O;
    logic [1:0] o_index;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int dat;
        int cyc;
        int done;
        int idx;
    } exp_t;
    exp_t sb[$];

    int m_mask[4];
    int m_rep[4];
    int m_last;
    bit m_loop;

    prewish_blink_sequencer #(
        .SYSCLK_DIV_BITS(DIV),
        .NUM_ENTRIES    (4)
    ) dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .STB_I  (STB_I),
        .ADR_I  (ADR_I),
        .DAT_I  (DAT_I),
        .ACK_O  (ACK_O),
        .STB_O  (STB_O),
        .DAT_O  (DAT_O),
        .o_busy (o_busy),
        .o_index(o_index),
        .o_done (o_done)
    );

    always #5 CLK_I = ~CLK_I;
    always @(posedge CLK_I) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    task automatic push(input int dat, input int c, input int done, input int idx, input int limit);
        exp_t e;
        if (c < limit) begin
            e.dat = dat; e.cyc = c; e.done = done; e.idx = idx;
            sb.push_back(e);
        end
    endtask

    // Cycle-level model of a run whose first ADVANCE cycle is a
    task automatic model_run(input int a, input int limit);
        int t;
        bit played;
        bit fin;
        t   = a;
        fin = 1'b0;
        while (!fin) begin
            played = 1'b0;
            for (int c = 0; c <= m_last; c++) begin
                if (m_rep[c] == 0) begin
                    t += 1;
                end else begin
                    push(m_mask[c], t + 1, 0, c, limit);
                    played = 1'b1;
                    t += 2 + m_rep[c] * CYC_PER_REP;
                end
            end
            if (m_loop && played) begin
                t += 1;
                if (t >= limit) fin = 1'b1;
            end else begin
                push(0, t, 1, -1, limit);
                fin = 1'b1;
            end
        end
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [7:0] d, output int w);
        ADR_I = a;
        DAT_I = d;
        STB_I = 1'b1;
        w     = cyc;
        @(posedge CLK_I);
        #1;
        STB_I = 1'b0;
        chk($sformatf("ack_adr%0d", a), int'(ACK_O), 1);
    endtask

    task automatic prog(input int n, input int mk, input int rp);
        int w;
        host_wr(4'(n), 8'(mk), w);
        host_wr(4'(n + 4), 8'(rp), w);
        m_mask[n] = mk;
        m_rep[n]  = rp;
    endtask

    task automatic set_ctrl(input logic [7:0] d, output int w);
        host_wr(4'd8, d, w);
        m_loop = d[1];
        m_last = int'(d[3:2]);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge CLK_I);
            #1;
        end
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(posedge CLK_I);
            #1;
            n++;
        end
        chk("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge CLK_I) begin
        if (RST_I) begin
            if (STB_O || o_done) begin
                if (sb.size() == 0) begin
                    chk("stb_unexpected", int'({STB_O, o_done}), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("stb_flag", int'(STB_O), 1);
                    chk("stb_dat", int'(DAT_O), e.dat);
                    chk("stb_cyc", cyc, e.cyc);
                    chk("stb_done", int'(o_done), e.done);
                    chk("stb_busy", int'(o_busy), 1);
                    if (e.idx >= 0) chk("stb_idx", int'(o_index), e.idx);
                end
            end else begin
                chk("dat_idle", int'(DAT_O), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, w2, a;
        for (int i = 0; i < 4; i++) begin
            m_mask[i] = 0;
            m_rep[i]  = 0;
        end
        m_last = 0;
        m_loop = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK_I);
        #1;
        chk("rst_outs", int'({ACK_O, STB_O, DAT_O, o_busy, o_index, o_done}), 0);
        #3 RST_I = 1'b1;
        @(posedge CLK_I);
        #1;
        repeat (20) @(posedge CLK_I);
        #1;
        chk("idle_busy", int'(o_busy), 0);
        chk("idle_ack", int'(ACK_O), 0);

        // Single entry
        prog(0, 'hA0, 2);
        set_ctrl(8'h01, w);
        model_run(w + 2, NO_LIMIT);
        drain(300);
        chk("single_busy_after", int'(o_busy), 0);
        chk("single_idx_after", int'(o_index), 0);

        // Skip and advance
        prog(0, 'h11, 1);
        prog(1, 'h22, 0);
        prog(2, 'h33, 3);
        prog(3, 'h44, 0);
        set_ctrl(8'h0D, w);
        model_run(w + 2, NO_LIMIT);
        drain(400);
        chk("skip_busy_after", int'(o_busy), 0);

        // Loop, then abort mid-dwell
        prog(0, 'hAA, 1);
        prog(1, 'h55, 1);
        set_ctrl(8'h07, w);
        a = w + 2;
        model_run(a, a + 151);
        push(0, a + 151, 0, -1, NO_LIMIT);
        wait_until(a + 150);
        set_ctrl(8'h00, w2);
        chk("abort_wr_cyc", w2, a + 150);
        drain(100);
        chk("abort_busy_after", int'(o_busy), 0);

        // All entries skipped with LOOP set
        for (int i = 0; i < 4; i++) prog(i, 'h10 + i, 0);
        set_ctrl(8'h0F, w);
        model_run(w + 2, NO_LIMIT);
        drain(20);
        chk("allskip_busy_after", int'(o_busy), 0);

        // Live mask edit while entry 0 plays, plus an ignored address
        prog(0, 'h3C, 1);
        set_ctrl(8'h03, w);
        a = w + 2;
        push('h3C, a + 1, 0, 0, NO_LIMIT);
        push('hFF, a + 36, 0, 0, NO_LIMIT);
        push('hFF, a + 71, 0, 0, NO_LIMIT);
        push(0, a + 81, 0, -1, NO_LIMIT);
        wait_until(a + 10);
        host_wr(4'd0, 8'hFF, w2);
        host_wr(4'd12, 8'h77, w2);
        wait_until(a + 80);
        set_ctrl(8'h00, w2);
        chk("edit_abort_cyc", w2, a + 80);
        drain(150);

        // Asynchronous reset mid-dwell
        prog(0, 'h11, 0);
        prog(1, 'h5A, 2);
        set_ctrl(8'h05, w);
        a = w + 2;
        push('h5A, a + 2, 0, 1, NO_LIMIT);
        wait_until(a + 20);
        #2;
        chk("pre_rst_busy", int'(o_busy), 1);
        chk("pre_rst_idx", int'(o_index), 1);
        RST_I = 1'b0;
        #1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_idx", int'(o_index), 0);
        chk("rst_stb", int'({STB_O, DAT_O, o_done, ACK_O}), 0);
        chk("rst_sb_empty", sb.size(), 0);
        sb.delete();
        #20 RST_I = 1'b1;
        @(posedge CLK_I);
        #1;
        repeat (100) @(posedge CLK_I);
        #1;
        chk("post_rst_busy", int'(o_busy), 0);
        for (int i = 0; i < 4; i++) begin
            m_mask[i] = 0;
            m_rep[i]  = 0;
        end
        set_ctrl(8'h01, w);
        model_run(w + 2, NO_LIMIT);
        drain(20);
        chk("post_rst_idle", int'(o_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
